frame_sequencer: RTL and testbench

Parametrised, multi-channel successor to the engine sample FSM. Sequences one audio frame of n_channels samples through four steps: input gain, n_pipelines DSP pipelines, wait for completion, then output mix. Adds a settle delay, a per-pipeline enable mask, a processing watchdog, overrun detection and a frame counter. Sits between the codec sample interface and the mixer/pipeline instances, and replaces the hard-wired engine state machine.

---
 rtl/frame_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_frame_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: one audio frame through gain, pipelines, settle/process, mix.
// Optional stats outputs compiled in with FRAME_SEQ_STATS_EN.
module frame_sequencer #(
  parameter int data_width     = 16,
  parameter int n_channels     = 2,
  parameter int n_pipelines    = 2,
  parameter int settle_cycles  = 1,
  parameter int timeout_cycles = 4096
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [n_channels*data_width-1:0] in_frame,
  input  logic                             frame_valid,
  output logic [n_channels*data_width-1:0] gain_frame,
  output logic                             gain_start,
  input  logic [n_channels*data_width-1:0] gained_frame,
  input  logic                             gain_done,
  output logic [n_channels*data_width-1:0] pipeline_frame,
  output logic                             pipeline_tick,
  input  logic [n_pipelines-1:0]           pipeline_ready,
  input  logic [n_pipelines-1:0]           pipeline_enable,
  output logic                             mix_start,
  input  logic [n_channels*data_width-1:0] mixed_frame,
  input  logic                             mix_done,
  output logic [n_channels*data_width-1:0] out_frame,
  output logic                             out_valid,
  output logic                             ready,
  output logic                             overrun,
  output logic                             timeout,
  input  logic                             clear_flags,
  output logic [31:0]                      frame_ctr
`ifdef FRAME_SEQ_STATS_EN
  ,
  output logic [15:0]                      overrun_count,
  output logic [15:0]                      max_latency
`endif
);

  localparam int FW = n_channels * data_width;
  localparam int SW = $clog2(settle_cycles + 1);
  localparam int TW = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
  localparam logic [SW-1:0] SLOAD = SW'(settle_cycles);
  localparam logic [TW-1:0] TMAX  = TW'(timeout_cycles - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAIN,
    S_SETTLE,
    S_PROCESS,
    S_MIX
  } state_t;

  state_t          r_state;
  logic [FW-1:0]   r_gain_frame;
  logic [FW-1:0]   r_pipe_frame;
  logic [FW-1:0]   r_out_frame;
  logic            r_gain_start;
  logic            r_tick;
  logic            r_mix_start;
  logic            r_out_valid;
  logic            r_ready;
  logic            r_overrun;
  logic            r_timeout;
  logic [31:0]     r_frame_ctr;
  logic [SW-1:0]   r_settle;
  logic [TW-1:0]   r_wd;

  logic w_done;
  logic w_accept;
  logic w_drop;
  logic w_finish;

  assign w_done   = &(pipeline_ready | ~pipeline_enable);
  assign w_accept = (r_state == S_IDLE) && frame_valid;
  assign w_drop   = (r_state != S_IDLE) && frame_valid;
  assign w_finish = (r_state == S_MIX) && mix_done;

  // Main sequencer: state, registered pulses, latched frames and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_gain_frame <= '0;
      r_pipe_frame <= '0;
      r_out_frame  <= '0;
      r_gain_start <= 1'b0;
      r_tick       <= 1'b0;
      r_mix_start  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_ready      <= 1'b1;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
      r_frame_ctr  <= '0;
      r_settle     <= '0;
      r_wd         <= '0;
    end else begin
      r_gain_start <= 1'b0;
      r_tick       <= 1'b0;
      r_mix_start  <= 1'b0;
      r_out_valid  <= 1'b0;
      if (clear_flags) begin
        r_overrun <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (w_drop) r_overrun <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (frame_valid) begin
            r_gain_frame <= in_frame;
            r_gain_start <= 1'b1;
            r_ready      <= 1'b0;
            r_state      <= S_GAIN;
          end
        end
        S_GAIN: begin
          if (gain_done && !r_gain_start) begin
            r_pipe_frame <= gained_frame;
            r_tick       <= 1'b1;
            r_settle     <= SLOAD;
            r_state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          r_settle <= r_settle - 1'b1;
          if (r_settle <= SW'(1)) begin
            r_wd    <= '0;
            r_state <= S_PROCESS;
          end
        end
        S_PROCESS: begin
          if (w_done) begin
            r_mix_start <= 1'b1;
            r_wd        <= '0;
            r_state     <= S_MIX;
          end else if (r_wd == TMAX) begin
            r_timeout   <= 1'b1;
            r_mix_start <= 1'b1;
            r_wd        <= '0;
            r_state     <= S_MIX;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_MIX: begin
          if (w_finish) begin
            r_out_frame <= mixed_frame;
            r_out_valid <= 1'b1;
            r_frame_ctr <= r_frame_ctr + 1'b1;
            r_ready     <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gain_frame     = r_gain_frame;
  assign gain_start     = r_gain_start;
  assign pipeline_frame = r_pipe_frame;
  assign pipeline_tick  = r_tick;
  assign mix_start      = r_mix_start;
  assign out_frame      = r_out_frame;
  assign out_valid      = r_out_valid;
  assign ready          = r_ready;
  assign overrun        = r_overrun;
  assign timeout        = r_timeout;
  assign frame_ctr      = r_frame_ctr;

`ifdef FRAME_SEQ_STATS_EN
  logic [15:0] r_ovr_cnt;
  logic [15:0] r_lat;
  logic [15:0] r_max_lat;

  // Saturating drop count, running frame latency and its maximum
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovr_cnt <= '0;
      r_lat     <= '0;
      r_max_lat <= '0;
    end else begin
      if (w_accept) begin
        r_lat <= 16'd1;
      end else if (r_state != S_IDLE && r_lat != 16'hFFFF) begin
        r_lat <= r_lat + 1'b1;
      end
      if (clear_flags) begin
        r_ovr_cnt <= '0;
        r_max_lat <= '0;
      end
      if (w_drop) begin
        if (clear_flags) r_ovr_cnt <= 16'd1;
        else if (r_ovr_cnt != 16'hFFFF) r_ovr_cnt <= r_ovr_cnt + 1'b1;
      end
      if (w_finish && (clear_flags || r_lat > r_max_lat)) begin
        r_max_lat <= r_lat;
      end
    end
  end

  assign overrun_count = r_ovr_cnt;
  assign max_latency   = r_max_lat;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed checks on a default instance (A) and an
// instance with settle_cycles=3, timeout_cycles=16 (B).
module tb_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, hold;
  logic [1:0]  pen, never;
  logic [31:0] din;
  logic        fv_a, fv_b;
  int          checks = 0;
  int          fails  = 0;
  int          n, n1, n2, n3, ov0;

  logic [31:0] a_gain_frame, a_gained, a_pipe_frame, a_mixed;
  logic [31:0] a_out_frame, a_frame_ctr;
  logic        a_gain_start, a_gain_done, a_tick, a_mix_start, a_mix_done;
  logic        a_out_valid, a_ready, a_overrun, a_timeout;
  logic [1:0]  a_prdy;
  logic [2:0]  a_pcnt;
  int          a_ovn = 0;

  logic [31:0] b_gain_frame, b_gained, b_pipe_frame, b_mixed;
  logic [31:0] b_out_frame, b_frame_ctr;
  logic        b_gain_start, b_gain_done, b_tick, b_mix_start, b_mix_done;
  logic        b_out_valid, b_ready, b_overrun, b_timeout;
  logic [1:0]  b_prdy;
  logic [2:0]  b_pcnt;

`ifdef FRAME_SEQ_STATS_EN
  logic [15:0] a_oc, a_ml, b_oc, b_ml;
`endif

  // Gain and mixer echo with fixed XOR patterns so each stage is visible
  assign a_gained = a_gain_frame ^ 32'h0F0F0F0F;
  assign a_mixed  = a_pipe_frame ^ 32'h00FF00FF;
  assign b_gained = b_gain_frame ^ 32'h0F0F0F0F;
  assign b_mixed  = b_pipe_frame ^ 32'h00FF00FF;
  assign a_prdy = hold ? 2'b11 : ({2{a_pcnt >= 3'd2}} & ~never);
  assign b_prdy = hold ? 2'b11 : ({2{b_pcnt >= 3'd2}} & ~never);

  // Responders: 1-cycle done pulses, pipelines ready 3 cycles after tick
  always_ff @(posedge clk) begin
    if (rst) begin
      a_gain_done <= 1'b0;
      a_mix_done  <= 1'b0;
      a_pcnt      <= '0;
      b_gain_done <= 1'b0;
      b_mix_done  <= 1'b0;
      b_pcnt      <= '0;
    end else begin
      a_gain_done <= a_gain_start;
      a_mix_done  <= a_mix_start;
      a_pcnt <= a_tick ? 3'd0 : (a_pcnt == 3'd7 ? a_pcnt : a_pcnt + 3'd1);
      b_gain_done <= b_gain_start;
      b_mix_done  <= b_mix_start;
      b_pcnt <= b_tick ? 3'd0 : (b_pcnt == 3'd7 ? b_pcnt : b_pcnt + 3'd1);
    end
  end

  // Count out_valid pulses of A
  always_ff @(posedge clk) begin
    if (a_out_valid) a_ovn <= a_ovn + 1;
  end

  frame_sequencer u_a (
    .clk(clk), .reset(rst), .in_frame(din), .frame_valid(fv_a),
    .gain_frame(a_gain_frame), .gain_start(a_gain_start),
    .gained_frame(a_gained), .gain_done(a_gain_done),
    .pipeline_frame(a_pipe_frame), .pipeline_tick(a_tick),
    .pipeline_ready(a_prdy), .pipeline_enable(pen),
    .mix_start(a_mix_start), .mixed_frame(a_mixed),
    .mix_done(a_mix_done), .out_frame(a_out_frame),
    .out_valid(a_out_valid), .ready(a_ready), .overrun(a_overrun),
    .timeout(a_timeout), .clear_flags(clr), .frame_ctr(a_frame_ctr)
`ifdef FRAME_SEQ_STATS_EN
    , .overrun_count(a_oc), .max_latency(a_ml)
`endif
  );

  frame_sequencer #(.settle_cycles(3), .timeout_cycles(16)) u_b (
    .clk(clk), .reset(rst), .in_frame(din), .frame_valid(fv_b),
    .gain_frame(b_gain_frame), .gain_start(b_gain_start),
    .gained_frame(b_gained), .gain_done(b_gain_done),
    .pipeline_frame(b_pipe_frame), .pipeline_tick(b_tick),
    .pipeline_ready(b_prdy), .pipeline_enable(pen),
    .mix_start(b_mix_start), .mixed_frame(b_mixed),
    .mix_done(b_mix_done), .out_frame(b_out_frame),
    .out_valid(b_out_valid), .ready(b_ready), .overrun(b_overrun),
    .timeout(b_timeout), .clear_flags(clr), .frame_ctr(b_frame_ctr)
`ifdef FRAME_SEQ_STATS_EN
    , .overrun_count(b_oc), .max_latency(b_ml)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int k = 1);
    repeat (k) @(negedge clk);
  endtask

  task automatic send(input int sel, input logic [31:0] d);
    din = d;
    if (sel == 0) fv_a = 1'b1;
    else fv_b = 1'b1;
    step();
    fv_a = 1'b0;
    fv_b = 1'b0;
  endtask

  // Steps until the selected DUT output is high, bounded by maxc
  task automatic wait_sig(input int sel, input int maxc, output int cnt);
    logic s;
    cnt = 0;
    while (1) begin
      case (sel)
        0:       s = a_out_valid;
        1:       s = a_mix_start;
        2:       s = a_tick;
        3:       s = b_out_valid;
        4:       s = b_mix_start;
        default: s = b_tick;
      endcase
      if (s || cnt >= maxc) break;
      step();
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; hold = 1'b0;
    pen = 2'b11; never = 2'b00;
    din = '0; fv_a = 1'b0; fv_b = 1'b0;
    step(3);
    chk("rst_ready", a_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_ctr", a_frame_ctr, 0);
    chk("rst_flags", {a_overrun, a_timeout}, 0);
    chk("rst_frames", a_gain_frame | a_out_frame, 0);
    rst = 1'b0;
    step();

    send(0, 32'hABCD1234);
    chk("a1_gain_start", a_gain_start, 1);
    chk("a1_gain_frame", a_gain_frame, 32'hABCD1234);
    chk("a1_busy", a_ready, 0);
    wait_sig(0, 40, n);
    chk("a1_latency", n, 8);
    chk("a1_out", a_out_frame, 32'hA43D1DC4);
    chk("a1_pipe", a_pipe_frame, 32'hA4C21D3B);
    chk("a1_ctr", a_frame_ctr, 1);
    chk("a1_ready", a_ready, 1);
`ifdef FRAME_SEQ_STATS_EN
    chk("a1_max_lat", a_ml, 8);
`endif
    step();
    chk("a1_pulse", a_out_valid, 0);
    chk("a1_ov_count", a_ovn, 1);

    pen = 2'b01; never = 2'b10;
    send(0, 32'h0000FFFF);
    wait_sig(0, 40, n);
    chk("a2_latency", n, 8);
    chk("a2_out", a_out_frame, 32'h0FF0F00F);
    chk("a2_timeout", a_timeout, 0);
    chk("a2_ctr", a_frame_ctr, 2);
    pen = 2'b11; never = 2'b00;
    step();

    send(0, 32'h11112222);
    din = 32'h55556666; fv_a = 1'b1;
    step();
    fv_a = 1'b0;
    chk("a3_overrun", a_overrun, 1);
    chk("a3_gain_kept", a_gain_frame, 32'h11112222);
    wait_sig(1, 40, n);
    din = 32'h77778888; fv_a = 1'b1;
    step();
    fv_a = 1'b0;
    wait_sig(0, 40, n);
    chk("a3_out", a_out_frame, 32'h1EE12DD2);
    step(3);
    chk("a3_ctr", a_frame_ctr, 3);
    chk("a3_ov_count", a_ovn, 3);
    chk("a3_ready", a_ready, 1);
`ifdef FRAME_SEQ_STATS_EN
    chk("a3_ovr_cnt", a_oc, 2);
`endif
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("a3_clear", a_overrun, 0);

    send(0, 32'h2468ACE0);
    fv_a = 1'b1; clr = 1'b1;
    step();
    fv_a = 1'b0; clr = 1'b0;
    chk("a4_set_wins", a_overrun, 1);
    wait_sig(0, 40, n);
    chk("a4_ctr", a_frame_ctr, 4);
`ifdef FRAME_SEQ_STATS_EN
    chk("a4_ovr_cnt", a_oc, 1);
    chk("a4_max_lat", a_ml, 8);
`endif
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;

    send(0, 32'h13572468);
    wait_sig(2, 20, n);
    step();
    ov0 = a_ovn;
    rst = 1'b1;
    step();
    chk("a5_rst_ready", a_ready, 1);
    chk("a5_rst_ov", a_out_valid, 0);
    chk("a5_rst_ctr", a_frame_ctr, 0);
    chk("a5_rst_frames", a_gain_frame | a_pipe_frame | a_out_frame, 0);
    chk("a5_rst_mix", a_mix_start, 0);
    rst = 1'b0;
    step(12);
    chk("a5_no_ov", a_ovn, ov0);
    send(0, 32'hCAFEF00D);
    wait_sig(0, 40, n);
    chk("a5_latency", n, 8);
    chk("a5_out", a_out_frame, 32'hC50EFFFD);
    chk("a5_ctr", a_frame_ctr, 1);

    pen = 2'b11; never = 2'b10;
    send(1, 32'h0BADBEEF);
    wait_sig(5, 20, n);
    chk("b1_tick_lat", n, 2);
    wait_sig(4, 60, n);
    chk("b1_wd_cycles", n, 19);
    chk("b1_timeout", b_timeout, 1);
    wait_sig(3, 10, n);
    chk("b1_ov_lat", n, 2);
    chk("b1_ctr", b_frame_ctr, 1);
    step();
    chk("b1_sticky", b_timeout, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("b1_clear", b_timeout, 0);

    never = 2'b00; hold = 1'b1;
    send(1, 32'h00010002);
    wait_sig(5, 20, n1);
    wait_sig(4, 20, n2);
    wait_sig(3, 20, n3);
    chk("b2_settle", n2, 4);
    chk("b2_latency", n1 + n2 + n3, 8);
    chk("b2_timeout", b_timeout, 0);
    chk("b2_ctr", b_frame_ctr, 2);
`ifdef FRAME_SEQ_STATS_EN
    chk("b2_max_lat", b_ml, n1 + n2 + n3);
`endif
    hold = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
